// File: rtl/pipe_pkg.sv
// Shared field widths, ALU function codes and issue-FSM states for the
// in-order issue controller.
package pipe_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned ADDR_W = 8;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FN_MUL = 4'd2;
    localparam logic [FUNC_W-1:0] FN_AND = 4'd3;
    localparam logic [FUNC_W-1:0] FN_OR  = 4'd4;
    localparam logic [FUNC_W-1:0] FN_MAX = FN_OR;

    typedef enum logic [1:0] {
        S_RUN,
        S_HAZ,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return (f <= FN_MAX);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with a
// two-port source compare for read-after-write hazard detection.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [REG_W-1:0] load_rd_i,
    input  logic             chk_valid_i,
    input  logic [REG_W-1:0] chk_rs_i,
    input  logic [REG_W-1:0] chk_rs1_i,
    output logic             hazard_o,
    output logic             empty_o
);

    logic [PIPE_DEPTH-1:0]            v_q;
    logic [PIPE_DEPTH-1:0][REG_W-1:0] rd_q;
    logic                             match;

    // Shift every cycle regardless of back-pressure; entry 0 takes the new issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            rd_q <= '0;
        end else begin
            v_q  <= {v_q[PIPE_DEPTH-2:0], load_i};
            rd_q <= {rd_q[PIPE_DEPTH-2:0], load_rd_i};
        end
    end

    // Compare both sources against every valid in-flight destination.
    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (v_q[i] && ((rd_q[i] == chk_rs_i) || (rd_q[i] == chk_rs1_i))) begin
                match = 1'b1;
            end
        end
    end

    assign hazard_o = chk_valid_i & match;

    // Looks one edge ahead: the oldest entry retires at this edge, so the
    // scoreboard is all-invalid after it when nothing younger or new remains.
    assign empty_o = ~(|v_q[PIPE_DEPTH-2:0]) & ~load_i;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: valid/ready intake, RAW hazard stalling,
// illegal-function rejection, drain-to-quiescent and statistics counters.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              hold,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t             state_q, state_d;
    logic               legal, hazard, sb_empty, active, accept, issue, stall;
    logic               iss_valid_q, err_q;
    logic [REG_W-1:0]   iss_rs_q, iss_rs1_q, iss_rd_q;
    logic [FUNC_W-1:0]  iss_func_q;
    logic [ADDR_W-1:0]  iss_addr_q;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    assign legal    = func_legal(in_func);
    assign active   = (state_q == S_RUN) || (state_q == S_HAZ);
    assign in_ready = rst_n & active & ~drain_req & ~hold & (~hazard | ~legal);
    assign accept   = in_valid & in_ready;
    assign issue    = accept & legal;
    assign stall    = in_valid & ~in_ready & active;

    pipe_scoreboard #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (issue),
        .load_rd_i  (in_rd),
        .chk_valid_i(in_valid),
        .chk_rs_i   (in_rs),
        .chk_rs1_i  (in_rs1),
        .hazard_o   (hazard),
        .empty_o    (sb_empty)
    );

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Next-state logic; drain_req outranks any same-cycle offer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (drain_req)                            state_d = S_DRAIN;
                else if (in_valid && legal && hazard && !hold) state_d = S_HAZ;
            end
            S_HAZ: begin
                if (drain_req)   state_d = S_DRAIN;
                else if (accept) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (!drain_req)    state_d = S_RUN;
                else if (sb_empty) state_d = S_DONE;
            end
            S_DONE: begin
                if (!drain_req) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Counter next values: issues and stalled offer cycles, both wrapping.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
        if (stall) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Issue registers and error pulse; fields keep their last value between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            err_q       <= 1'b0;
            iss_rs_q    <= '0;
            iss_rs1_q   <= '0;
            iss_rd_q    <= '0;
            iss_func_q  <= '0;
            iss_addr_q  <= '0;
        end else begin
            iss_valid_q <= issue;
            err_q       <= accept & ~legal;
            if (issue) begin
                iss_rs_q   <= in_rs;
                iss_rs1_q  <= in_rs1;
                iss_rd_q   <= in_rd;
                iss_func_q <= in_func;
                iss_addr_q <= in_addr;
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign drain_done  = (state_q == S_DONE);
    assign iss_valid   = iss_valid_q;
    assign iss_rs      = iss_rs_q;
    assign iss_rs1     = iss_rs1_q;
    assign iss_rd      = iss_rd_q;
    assign iss_func    = iss_func_q;
    assign iss_addr    = iss_addr_q;
    assign err_illegal = err_q;
    assign issue_cnt   = issue_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed, table-driven bench for pipe_issue_ctrl: each row is one clock
// cycle of inputs with the expected in_ready before the edge and the
// expected registered outputs after it.
module tb_pipe_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, hold, drain_req, drain_done;
    logic [3:0] in_rs, in_rs1, in_rd, in_func;
    logic [7:0] in_addr;
    logic       iss_valid, err_illegal;
    logic [3:0] iss_rs, iss_rs1, iss_rd, iss_func;
    logic [7:0] iss_addr;
    logic [15:0] issue_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(
        .PIPE_DEPTH(3),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rs1     (in_rs1),
        .in_rd      (in_rd),
        .in_func    (in_func),
        .in_addr    (in_addr),
        .hold       (hold),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .iss_valid  (iss_valid),
        .iss_rs     (iss_rs),
        .iss_rs1    (iss_rs1),
        .iss_rd     (iss_rd),
        .iss_func   (iss_func),
        .iss_addr   (iss_addr),
        .err_illegal(err_illegal),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [3:0]  rs, rs1, rd, fn;
        logic [7:0]  ad;
        logic        hold, drn;
        logic        rdy;
        logic        ivld;
        logic [3:0]  ird;
        logic        err;
        logic [15:0] icnt, scnt;
        logic        ddone;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic v, input logic [3:0] rs, rs1, rd, fn,
                                input logic [7:0] ad, input logic hl, dr,
                                input logic rdy, ivld, input logic [3:0] ird,
                                input logic err, input logic [15:0] icnt, scnt,
                                input logic ddone);
        vec_t x;
        x.v = v; x.rs = rs; x.rs1 = rs1; x.rd = rd; x.fn = fn; x.ad = ad;
        x.hold = hl; x.drn = dr; x.rdy = rdy; x.ivld = ivld; x.ird = ird;
        x.err = err; x.icnt = icnt; x.scnt = scnt; x.ddone = ddone;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        in_valid  = x.v;
        in_rs     = x.rs;
        in_rs1    = x.rs1;
        in_rd     = x.rd;
        in_func   = x.fn;
        in_addr   = x.ad;
        hold      = x.hold;
        drain_req = x.drn;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, x.rdy});
        @(posedge clk);
        #1;
        chk({tag, ".iss_valid"},   {31'd0, iss_valid},   {31'd0, x.ivld});
        chk({tag, ".iss_rd"},      {28'd0, iss_rd},      {28'd0, x.ird});
        chk({tag, ".err_illegal"}, {31'd0, err_illegal}, {31'd0, x.err});
        chk({tag, ".issue_cnt"},   {16'd0, issue_cnt},   {16'd0, x.icnt});
        chk({tag, ".stall_cnt"},   {16'd0, stall_cnt},   {16'd0, x.scnt});
        chk({tag, ".drain_done"},  {31'd0, drain_done},  {31'd0, x.ddone});
    endtask

    initial begin
        // Reset with an instruction offered: nothing may be accepted.
        rst_n = 1'b0; in_valid = 1'b1; in_rs = 4'd1; in_rs1 = 4'd2; in_rd = 4'd3;
        in_func = 4'd0; in_addr = 8'h00; hold = 1'b0; drain_req = 1'b0;
        #2;
        chk("rst.in_ready",  {31'd0, in_ready},  0);
        chk("rst.iss_valid", {31'd0, iss_valid}, 0);
        chk("rst.issue_cnt", {16'd0, issue_cnt}, 0);
        chk("rst.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("rst.drain_done",{31'd0, drain_done},0);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent stream, RAW stall, illegal while hazard pending.
        tab.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0,  0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 2, 3, 0, 8'h10, 0, 0,  1, 1,  3, 0, 1, 0, 0));
        tab.push_back(mk(1, 4, 5, 6, 4, 8'h11, 0, 0,  1, 1,  6, 0, 2, 0, 0));
        tab.push_back(mk(1, 7, 8, 9, 1, 8'h12, 0, 0,  1, 1,  9, 0, 3, 0, 0));
        tab.push_back(mk(1, 1, 2, 3, 0, 8'h20, 0, 0,  1, 1,  3, 0, 4, 0, 0));
        tab.push_back(mk(1, 3, 0, 10, 3, 8'h21, 0, 0, 0, 0,  3, 0, 4, 1, 0));
        tab.push_back(mk(1, 3, 0, 10, 3, 8'h21, 0, 0, 0, 0,  3, 0, 4, 2, 0));
        tab.push_back(mk(1, 3, 0, 10, 3, 8'h21, 0, 0, 0, 0,  3, 0, 4, 3, 0));
        tab.push_back(mk(1, 3, 0, 10, 3, 8'h21, 0, 0, 1, 1, 10, 0, 5, 3, 0));
        tab.push_back(mk(1, 10, 0, 11, 0, 8'h22, 0, 0, 0, 0, 10, 0, 5, 4, 0));
        tab.push_back(mk(1, 10, 0, 12, 4'hA, 8'h23, 0, 0, 1, 0, 10, 1, 5, 4, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 10, 0, 5, 4, 0));

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i], $sformatf("row%0d", i));
        end
        chk("held.iss_func", {28'd0, iss_func}, 3);
        chk("held.iss_addr", {24'd0, iss_addr}, 32'h21);

        // Hold with a dependent offer: the scoreboard keeps draining under hold.
        apply(mk(1, 0, 0, 14, 0, 8'h30, 0, 0, 1, 1, 14, 0, 6, 4, 0), "hold.pre");
        for (int i = 0; i < 5; i++) begin
            apply(mk(1, 14, 14, 13, 2, 8'h31, 1, 0, 0, 0, 14, 0, 6, 16'(5 + i), 0),
                  $sformatf("hold%0d", i));
        end
        apply(mk(1, 14, 14, 13, 2, 8'h31, 0, 0, 1, 1, 13, 0, 7, 9, 0), "hold.rel");
        chk("hold.iss_func", {28'd0, iss_func}, 2);
        chk("hold.iss_rs",   {28'd0, iss_rs},   14);

        // Drain after two issues; drain_req arrives together with an offer.
        apply(mk(1, 0, 0, 1, 0, 8'h40, 0, 0, 1, 1, 1, 0, 8, 9, 0),  "drn.a");
        apply(mk(1, 0, 0, 2, 0, 8'h41, 0, 0, 1, 1, 2, 0, 9, 9, 0),  "drn.b");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 1, 0, 0, 2, 0, 9, 10, 0), "drn.req");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 1, 0, 0, 2, 0, 9, 10, 0), "drn.w1");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 1, 0, 0, 2, 0, 9, 10, 1), "drn.w2");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 1, 0, 0, 2, 0, 9, 10, 1), "drn.done");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 0, 0, 0, 2, 0, 9, 10, 0), "drn.drop");
        apply(mk(1, 0, 0, 5, 0, 8'h42, 0, 0, 1, 1, 5, 0, 10, 10, 0), "drn.resume");

        // Asynchronous reset in the middle of a RAW stall.
        apply(mk(1, 0, 0, 7, 0, 8'h50, 0, 0, 1, 1, 7, 0, 11, 10, 0), "ar.prod");
        apply(mk(1, 7, 0, 8, 2, 8'h51, 0, 0, 0, 0, 7, 0, 11, 11, 0), "ar.stall");
        rst_n = 1'b0;
        #1;
        chk("ar.in_ready",  {31'd0, in_ready},  0);
        chk("ar.iss_rd",    {28'd0, iss_rd},    0);
        chk("ar.issue_cnt", {16'd0, issue_cnt}, 0);
        chk("ar.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("ar.iss_addr",  {24'd0, iss_addr},  0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar.rel.in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("ar.rel.iss_valid", {31'd0, iss_valid}, 1);
        chk("ar.rel.iss_rd",    {28'd0, iss_rd},    8);
        chk("ar.rel.issue_cnt", {16'd0, issue_cnt}, 1);
        chk("ar.rel.stall_cnt", {16'd0, stall_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
